instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Decoupling queue between the instruction-cache fetch stage and the decode stage.
- Accepts one fetch bundle of up to Cfg.INSTR_PER_FETCH instructions per cycle, tags each instruction with its PC, and buffers them in a circular queue.
- Presents the oldest DEC_WIDTH instructions to decode, which may consume any prefix of them each cycle.
- Widths are derived from the global cfg_t configuration struct.

Parameters:
- Cfg, config_pkg::EmptyCfg: global configuration. Uses INSTR_PER_FETCH, ILEN and VLEN.
- DEPTH, 16: number of instruction entries. Must be a power of two and at least 2*Cfg.INSTR_PER_FETCH (elaboration-time assertion).
- DEC_WIDTH, 4: number of decode lanes presented per cycle. Must be between 1 and DEPTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard all queued entries (redirect or mispredict).
- fetch_valid_i  in  1  fetch bundle valid.
- fetch_ready_o  out  1  queue can accept a full bundle.
- fetch_pc_i  in  Cfg.VLEN  PC of lane 0 of the bundle.
- fetch_instr_i  in  Cfg.INSTR_PER_FETCH*Cfg.ILEN  instructions; lane i occupies bits [i*ILEN +: ILEN].
- fetch_mask_i  in  Cfg.INSTR_PER_FETCH  per-lane valid mask; must be thermometer (contiguous from lane 0).
- dec_valid_o  out  DEC_WIDTH  lane i holds a valid instruction.
- dec_instr_o  out  DEC_WIDTH*Cfg.ILEN  oldest instructions, lane 0 = oldest.
- dec_pc_o  out  DEC_WIDTH*Cfg.VLEN  PC of each decode lane.
- dec_deq_i  in  $clog2(DEC_WIDTH+1)  number of lanes consumed this cycle.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - head, tail and count are cleared to 0.
  - dec_valid_o = 0, count_o = 0, fetch_ready_o = 1. fetch_ready_o stays 1 while rst_ni is held low, because count is 0.
  - Storage contents are don't-care.
- Storage: DEPTH entries, each holding {instr[ILEN], pc[VLEN]}. head and tail are $clog2(DEPTH)-bit pointers and wrap modulo DEPTH naturally.
- Enqueue:
  - Fires when fetch_valid_i && fetch_ready_o && !flush_i.
  - enq_n = popcount(fetch_mask_i).
  - Lane i (for i < enq_n) is written to entry (tail+i) mod DEPTH with pc = fetch_pc_i + 4*i (VLEN-bit, wrap-around arithmetic).
  - tail advances by enq_n.
  - A bundle with mask 0 is accepted as a no-op.
- fetch_ready_o = (DEPTH - count) >= Cfg.INSTR_PER_FETCH.
  - Computed from the registered count only; a same-cycle dequeue does not raise ready.
  - It is a combinational function of the count register and has no dependence on fetch_valid_i.
- Decode outputs:
  - Combinational read of entries (head+i) mod DEPTH.
  - dec_valid_o[i] = (count > i).
  - Entries written at edge N become visible in the cycle after edge N; there is no enqueue-to-dequeue bypass.
  - When dec_valid_o[i] = 0, instr and pc for lane i are don't-care.
- Dequeue: head advances by dec_deq_i (modulo DEPTH), applied when !flush_i.
- Count update: count_next = count + enq_n - dec_deq_i.
  - Simultaneous enqueue and dequeue in one cycle are both applied.
  - Full and empty are distinguished by count, not by pointer equality.
- Flush (dominant):
  - On the edge where flush_i = 1, head = tail = count = 0.
  - Any same-cycle enqueue or dequeue is ignored.
  - Outputs show empty from the next cycle.
- Wrap-around: a bundle or decode window that straddles entry DEPTH-1 into entry 0 must read and write correctly.
- Simulation-only assertions:
  - fetch_mask_i is thermometer whenever fetch_valid_i = 1.
  - dec_deq_i <= popcount(dec_valid_o).
  - count never exceeds DEPTH.
  - fetch_pc_i is 4-byte aligned whenever fetch_valid_i = 1.

Test Plan:
Configuration for all scenarios: INSTR_PER_FETCH=4, ILEN=32, VLEN=32, DEPTH=16, DEC_WIDTH=4.
1. Reset, then one bundle with pc=0x8000_0000, mask=4'b1111, instr=A,B,C,D, dec_deq_i=0 -> next cycle: count_o=4, dec_valid_o=4'b1111, dec_pc_o = 0x80000000/04/08/0C, instr A..D. Same cycle as the enqueue: dec_valid_o=0.
2. Enqueue 4 full bundles with dec_deq_i=0 -> count_o=16 and fetch_ready_o=0. Next, dec_deq_i=4 for one cycle -> count_o=12 and fetch_ready_o=1 in the following cycle (not in the dequeue cycle).
3. Partial mask 4'b0011 at pc=0x100, with 2 entries already queued -> count_o=4; lanes 2 and 3 show pc 0x100 and 0x104. Then dec_deq_i=3 -> count_o=1 and lane 0 shows pc 0x104.
4. Simultaneous enqueue of 4 and dec_deq_i=2 at count=6 -> count_o=8 next cycle. Drive enough traffic to wrap tail past entry 15 -> pcs stay in order across the wrap.
5. flush_i=1 in the same cycle as fetch_valid_i=1 and dec_deq_i=2, at count=9 -> next cycle count_o=0, dec_valid_o=0, fetch_ready_o=1. The bundle presented in the flush cycle never appears at the decode outputs.
6. Deassert rst_ni asynchronously mid-stream at count=10 -> outputs clear immediately (count_o=0, dec_valid_o=0) without a clock edge. After release, the first enqueue lands at entry 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - PC-tagging circular queue between fetch and decode
package config_pkg;
    typedef struct packed {
        int unsigned INSTR_PER_FETCH;
        int unsigned ILEN;
        int unsigned VLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{INSTR_PER_FETCH: 4, ILEN: 32, VLEN: 32};
endpackage

module instr_fetch_queue #(
    parameter config_pkg::cfg_t Cfg       = config_pkg::EmptyCfg,
    parameter int               DEPTH     = 16,
    parameter int               DEC_WIDTH = 4
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,
    input  logic                                                 flush_i,
    input  logic                                                 fetch_valid_i,
    output logic                                                 fetch_ready_o,
    input  logic [Cfg.VLEN-1:0]                                  fetch_pc_i,
    input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]              fetch_instr_i,
    input  logic [Cfg.INSTR_PER_FETCH-1:0]                       fetch_mask_i,
    output logic [DEC_WIDTH-1:0]                                 dec_valid_o,
    output logic [DEC_WIDTH*Cfg.ILEN-1:0]                        dec_instr_o,
    output logic [DEC_WIDTH*Cfg.VLEN-1:0]                        dec_pc_o,
    input  logic [$clog2(DEC_WIDTH+1)-1:0]                       dec_deq_i,
    output logic [$clog2(DEPTH+1)-1:0]                           count_o
);
    localparam int IPF   = int'(Cfg.INSTR_PER_FETCH);
    localparam int ILEN  = int'(Cfg.ILEN);
    localparam int VLEN  = int'(Cfg.VLEN);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DEQ_W = $clog2(DEC_WIDTH + 1);
    localparam int ENQ_W = $clog2(IPF + 1);

    if (DEPTH < 2 * IPF || (DEPTH & (DEPTH - 1)) != 0 || DEC_WIDTH < 1 || DEC_WIDTH > DEPTH) begin : g_bad_cfg
        $error("instr_fetch_queue: illegal DEPTH / DEC_WIDTH for this configuration");
    end

    logic [ILEN-1:0]  mem_instr [DEPTH];
    logic [VLEN-1:0]  mem_pc    [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [ENQ_W-1:0] enq_n;
    logic [ENQ_W-1:0] enq_cnt;
    logic             enq_fire;
    logic [CNT_W-1:0] dec_avail;

    // Ready looks only at the registered count so it never depends on fetch_valid_i.
    assign fetch_ready_o = (count <= CNT_W'(DEPTH - IPF));
    assign enq_fire      = fetch_valid_i && fetch_ready_o && !flush_i;
    assign enq_cnt       = enq_fire ? enq_n : '0;
    assign count_o       = count;
    assign dec_avail     = (count >= CNT_W'(DEC_WIDTH)) ? CNT_W'(DEC_WIDTH) : count;

    // Number of valid lanes in the incoming bundle.
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < IPF; i++) begin
            enq_n = enq_n + ENQ_W'(fetch_mask_i[i]);
        end
    end

    // Write accepted lanes at tail+i, tagging each with its sequential PC.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < IPF; i++) begin
            if (enq_fire && (ENQ_W'(i) < enq_n)) begin
                mem_instr[tail + PTR_W'(i)] <= fetch_instr_i[i*ILEN +: ILEN];
                mem_pc[tail + PTR_W'(i)]    <= fetch_pc_i + VLEN'(4 * i);
            end
        end
    end

    // Pointer and occupancy update; flush wins over any same-cycle traffic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PTR_W'(enq_cnt);
            head  <= head + PTR_W'(dec_deq_i);
            count <= count + CNT_W'(enq_cnt) - CNT_W'(dec_deq_i);
        end
    end

    // Present the oldest DEC_WIDTH entries; the window may wrap past the last entry.
    always_comb begin
        dec_valid_o = '0;
        dec_instr_o = '0;
        dec_pc_o    = '0;
        for (int i = 0; i < DEC_WIDTH; i++) begin
            dec_valid_o[i]              = (count > CNT_W'(i));
            dec_instr_o[i*ILEN +: ILEN] = mem_instr[head + PTR_W'(i)];
            dec_pc_o[i*VLEN +: VLEN]    = mem_pc[head + PTR_W'(i)];
        end
    end

    a_mask_thermometer: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fetch_valid_i |-> ((fetch_mask_i & (fetch_mask_i + IPF'(1))) == '0));
    a_deq_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (CNT_W'(dec_deq_i) <= dec_avail));
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (count <= CNT_W'(DEPTH)));
    a_pc_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fetch_valid_i |-> (fetch_pc_i[1:0] == 2'b00));

    logic [DEQ_W-1:0] unused_deq_w;
    assign unused_deq_w = '0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;
    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         fetch_valid;
    logic         fetch_ready;
    logic [31:0]  fetch_pc;
    logic [127:0] fetch_instr;
    logic [3:0]   fetch_mask;
    logic [3:0]   dec_valid;
    logic [127:0] dec_instr;
    logic [127:0] dec_pc;
    logic [2:0]   dec_deq;
    logic [4:0]   count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic [3:0]  pre_valid;
    logic        pre_ready;

    instr_fetch_queue dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .fetch_valid_i (fetch_valid),
        .fetch_ready_o (fetch_ready),
        .fetch_pc_i    (fetch_pc),
        .fetch_instr_i (fetch_instr),
        .fetch_mask_i  (fetch_mask),
        .dec_valid_o   (dec_valid),
        .dec_instr_o   (dec_instr),
        .dec_pc_o      (dec_pc),
        .dec_deq_i     (dec_deq),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    // Drive one cycle of stimulus starting just after a rising edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [3:0] mask,
                        input logic [127:0] ins, input int deq, input logic fl);
        logic acc;
        fetch_valid = v;
        fetch_pc    = pc;
        fetch_mask  = mask;
        fetch_instr = ins;
        dec_deq     = 3'(deq);
        flush       = fl;
        #1;
        pre_valid = dec_valid;
        pre_ready = fetch_ready;
        acc = v && fetch_ready && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else if (acc) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) exp_q.push_back({pc + 32'(4 * i), ins[i*32 +: 32]});
            end
        end
        fetch_valid = 1'b0;
        fetch_mask  = '0;
        dec_deq     = '0;
        flush       = 1'b0;
    endtask

    // Monitor: checks occupancy and every valid lane, then retires consumed entries.
    always @(negedge clk) begin : mon
        int n;
        logic [3:0] ev;
        if (mon_en) begin
            n = exp_q.size();
            chk("mon_count", 64'(count), 64'(n));
            ev = (n >= 4) ? 4'b1111 : 4'((1 << n) - 1);
            chk("mon_valid", 64'(dec_valid), 64'(ev));
            for (int i = 0; i < 4; i++) begin
                if (i < n) begin
                    chk("mon_pc", 64'(dec_pc[i*32 +: 32]), 64'(exp_q[i][63:32]));
                    chk("mon_instr", 64'(dec_instr[i*32 +: 32]), 64'(exp_q[i][31:0]));
                end
            end
            if (!flush && rst_n) begin
                for (int i = 0; i < int'(dec_deq); i++) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    else chk("mon_underflow", 64'(dec_deq), 64'(i));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        fetch_valid = 1'b0;
        fetch_pc = '0;
        fetch_instr = '0;
        fetch_mask = '0;
        dec_deq = '0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(dec_valid), 64'd0);
        chk("rst_ready", 64'(fetch_ready), 64'd1);
        #10 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // 1: single full bundle
        step(1'b1, 32'h8000_0000, 4'b1111, mk(32'hA000_0000), 0, 1'b0);
        chk("t1_same_cycle_valid", 64'(pre_valid), 64'd0);
        chk("t1_count", 64'(count), 64'd4);
        chk("t1_valid", 64'(dec_valid), 64'hF);
        chk("t1_pc1", 64'(dec_pc[63:32]), 64'h8000_0004);
        chk("t1_pc3", 64'(dec_pc[127:96]), 64'h8000_000C);
        chk("t1_instr3", 64'(dec_instr[127:96]), 64'hA000_0003);

        // 2: fill to DEPTH, then one dequeue
        step(1'b1, 32'h8000_0010, 4'b1111, mk(32'hA100_0000), 0, 1'b0);
        step(1'b1, 32'h8000_0020, 4'b1111, mk(32'hA200_0000), 0, 1'b0);
        step(1'b1, 32'h8000_0030, 4'b1111, mk(32'hA300_0000), 0, 1'b0);
        chk("t2_count_full", 64'(count), 64'd16);
        chk("t2_ready_full", 64'(fetch_ready), 64'd0);
        step(1'b0, 32'h0, 4'b0000, '0, 4, 1'b0);
        chk("t2_ready_deq_cycle", 64'(pre_ready), 64'd0);
        chk("t2_count", 64'(count), 64'd12);
        chk("t2_ready", 64'(fetch_ready), 64'd1);

        // 3: partial masks
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 4'b0000, '0, 4, 1'b0);
        step(1'b1, 32'h0000_0040, 4'b0011, mk(32'hB000_0000), 0, 1'b0);
        step(1'b1, 32'h0000_0100, 4'b0011, mk(32'hC000_0000), 0, 1'b0);
        chk("t3_count", 64'(count), 64'd4);
        chk("t3_pc2", 64'(dec_pc[95:64]), 64'h100);
        chk("t3_pc3", 64'(dec_pc[127:96]), 64'h104);
        step(1'b0, 32'h0, 4'b0000, '0, 3, 1'b0);
        chk("t3_count_after", 64'(count), 64'd1);
        chk("t3_pc0", 64'(dec_pc[31:0]), 64'h104);

        // 4: simultaneous enqueue/dequeue, then wrap traffic
        step(1'b1, 32'h0000_0200, 4'b1111, mk(32'hD000_0000), 0, 1'b0);
        step(1'b1, 32'h0000_0210, 4'b0001, mk(32'hD100_0000), 0, 1'b0);
        step(1'b1, 32'h0000_0220, 4'b1111, mk(32'hD200_0000), 2, 1'b0);
        chk("t4_count", 64'(count), 64'd8);
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h0000_0300 + 32'(16 * k), 4'b1111, mk(32'hE000_0000 + 32'(k << 8)), 4, 1'b0);
        chk("t4_count_wrap", 64'(count), 64'd8);
        chk("t4_pc0_wrap", 64'(dec_pc[31:0]), 64'h310);
        chk("t4_pc3_wrap", 64'(dec_pc[127:96]), 64'h31C);

        // 5: flush dominates
        step(1'b1, 32'h0000_0400, 4'b0001, mk(32'hF000_0000), 0, 1'b0);
        chk("t5_count_pre", 64'(count), 64'd9);
        step(1'b1, 32'h0000_0500, 4'b1111, mk(32'hF100_0000), 2, 1'b1);
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_valid", 64'(dec_valid), 64'd0);
        chk("t5_ready", 64'(fetch_ready), 64'd1);
        step(1'b1, 32'h0000_0600, 4'b1111, mk(32'hF200_0000), 0, 1'b0);
        chk("t5_pc0_after", 64'(dec_pc[31:0]), 64'h600);

        // 6: asynchronous reset mid-stream
        step(1'b1, 32'h0000_0610, 4'b1111, mk(32'hF300_0000), 0, 1'b0);
        step(1'b1, 32'h0000_0620, 4'b0011, mk(32'hF400_0000), 0, 1'b0);
        chk("t6_count_pre", 64'(count), 64'd10);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_async_count", 64'(count), 64'd0);
        chk("t6_async_valid", 64'(dec_valid), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'h0000_0700, 4'b1111, mk(32'h7700_0000), 0, 1'b0);
        chk("t6_entry0_pc", 64'(dut.mem_pc[0]), 64'h700);
        chk("t6_pc0", 64'(dec_pc[31:0]), 64'h700);
        chk("t6_count", 64'(count), 64'd4);

        step(1'b0, 32'h0, 4'b0000, '0, 4, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
